// File: rtl/zap_localparams.sv
// Shared ZAP bus constants: Wishbone cycle-type identifiers used by all bus masters
// and arbiters.
package zap_localparams;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage : zap_localparams

// File: rtl/zap_wb_pkg.sv
// Wishbone request bundle shared by the N-way arbiter and its picker.
package zap_wb_pkg;

    import zap_localparams::*;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
    } wb_req_t;

    // Idle bus as seen after reset: no cycle, end-of-burst type.
    localparam wb_req_t WB_REQ_RESET = '{cyc: 1'b0, stb: 1'b0, wen: 1'b0, sel: 4'h0,
                                         dat: 32'h0, adr: 32'h0, cti: CTI_EOB};

endpackage : zap_wb_pkg

// File: rtl/zap_wb_arb_pick.sv
// Combinational requester picker. ZAP_WB_ARB_RR_EN selects round-robin starting after
// i_ptr (current owner last); otherwise the highest requesting index wins.
module zap_wb_arb_pick #(
    parameter int NUM_MASTERS = 3,
    parameter int GW          = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [GW-1:0]          i_ptr,
    output logic [GW-1:0]          o_idx
);

`ifdef ZAP_WB_ARB_RR_EN
    logic [GW-1:0] w_cand;

    // Scan downward so the nearest index after i_ptr is the last assignment.
    always_comb begin
        o_idx  = i_ptr;
        w_cand = i_ptr;
        for (int j = NUM_MASTERS; j >= 1; j--) begin
            w_cand = GW'((int'(i_ptr) + j) % NUM_MASTERS);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (i_req[i]) begin
                o_idx = GW'(i);
            end
        end
    end
`endif

endmodule : zap_wb_arb_pick

// File: rtl/zap_wb_arbiter_n.sv
// N-master Wishbone arbiter with burst lock and beat-boundary re-arbitration.
// Define ZAP_WB_ARB_RR_EN for round-robin selection; default is fixed priority.
module zap_wb_arbiter_n #(
    parameter int NUM_MASTERS = 3
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_MASTERS-1:0]       i_m_cyc_nxt,
    input  logic [NUM_MASTERS-1:0]       i_m_stb_nxt,
    input  logic [NUM_MASTERS-1:0]       i_m_wen_nxt,
    input  logic [NUM_MASTERS-1:0][3:0]  i_m_sel_nxt,
    input  logic [NUM_MASTERS-1:0][31:0] i_m_dat_nxt,
    input  logic [NUM_MASTERS-1:0][31:0] i_m_adr_nxt,
    input  logic [NUM_MASTERS-1:0][2:0]  i_m_cti_nxt,
    output logic [NUM_MASTERS-1:0]       o_m_ack,
    output logic [NUM_MASTERS-1:0]       o_m_err,
    output logic [NUM_MASTERS-1:0]       o_gnt,
    output logic                         o_wb_cyc_nxt,
    output logic                         o_wb_stb_nxt,
    output logic                         o_wb_wen_nxt,
    output logic [3:0]                   o_wb_sel_nxt,
    output logic [31:0]                  o_wb_dat_nxt,
    output logic [31:0]                  o_wb_adr_nxt,
    output logic [2:0]                   o_wb_cti_nxt,
    output logic                         o_wb_cyc,
    output logic                         o_wb_stb,
    output logic                         o_wb_wen,
    output logic [3:0]                   o_wb_sel,
    output logic [31:0]                  o_wb_dat,
    output logic [31:0]                  o_wb_adr,
    output logic [2:0]                   o_wb_cti,
    input  logic                         i_wb_ack,
    input  logic                         i_wb_err
);

    import zap_localparams::*;
    import zap_wb_pkg::*;

    localparam int GW = $clog2(NUM_MASTERS);

    wb_req_t       w_req [NUM_MASTERS];
    wb_req_t       w_bus_nxt;
    wb_req_t       r_bus;
    logic [GW-1:0] r_gnt;
    logic [GW-1:0] w_gnt_nxt;
    logic [GW-1:0] w_pick;
    logic [GW-1:0] w_rr_ptr;
    logic          w_beat_done;
    logic          w_may_switch;
    logic          w_release;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
            assign w_req[gi] = '{cyc: i_m_cyc_nxt[gi], stb: i_m_stb_nxt[gi],
                                 wen: i_m_wen_nxt[gi], sel: i_m_sel_nxt[gi],
                                 dat: i_m_dat_nxt[gi], adr: i_m_adr_nxt[gi],
                                 cti: i_m_cti_nxt[gi]};
        end
    endgenerate

    zap_wb_arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .GW          (GW)
    ) u_pick (
        .i_req (i_m_cyc_nxt),
        .i_ptr (w_rr_ptr),
        .o_idx (w_pick)
    );

    // An error beat completes a beat just like an ack; only an EOB beat or a dropped
    // CYC lets another master in.
    assign w_beat_done  = r_bus.stb & (i_wb_ack | i_wb_err);
    assign w_may_switch = ~r_bus.stb | w_beat_done;
    assign w_release    = ~i_m_cyc_nxt[r_gnt] | (w_beat_done & (r_bus.cti == CTI_EOB));
    assign w_gnt_nxt    = (w_may_switch & w_release & (|i_m_cyc_nxt)) ? w_pick : r_gnt;
    assign w_bus_nxt    = w_req[w_gnt_nxt];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt <= '0;
            r_bus <= WB_REQ_RESET;
        end else begin
            r_gnt <= w_gnt_nxt;
            r_bus <= w_bus_nxt;
        end
    end

`ifdef ZAP_WB_ARB_RR_EN
    logic [GW-1:0] r_rr_ptr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_nxt != r_gnt) begin
            r_rr_ptr <= w_gnt_nxt;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = '0;
`endif

    always_comb begin
        o_gnt          = '0;
        o_m_ack        = '0;
        o_m_err        = '0;
        o_gnt[r_gnt]   = 1'b1;
        o_m_ack[r_gnt] = i_wb_ack;
        o_m_err[r_gnt] = i_wb_err;
    end

    assign o_wb_cyc_nxt = w_bus_nxt.cyc;
    assign o_wb_stb_nxt = w_bus_nxt.stb;
    assign o_wb_wen_nxt = w_bus_nxt.wen;
    assign o_wb_sel_nxt = w_bus_nxt.sel;
    assign o_wb_dat_nxt = w_bus_nxt.dat;
    assign o_wb_adr_nxt = w_bus_nxt.adr;
    assign o_wb_cti_nxt = w_bus_nxt.cti;

    assign o_wb_cyc = r_bus.cyc;
    assign o_wb_stb = r_bus.stb;
    assign o_wb_wen = r_bus.wen;
    assign o_wb_sel = r_bus.sel;
    assign o_wb_dat = r_bus.dat;
    assign o_wb_adr = r_bus.adr;
    assign o_wb_cti = r_bus.cti;

endmodule : zap_wb_arbiter_n

// File: tb/tb_zap_wb_arbiter_n.sv
// Directed bench for zap_wb_arbiter_n (3 masters); grant-order expectations follow
// ZAP_WB_ARB_RR_EN when it is defined.
module tb_zap_wb_arbiter_n;

    localparam logic [2:0] EOB   = 3'b111;
    localparam logic [2:0] BURST = 3'b010;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [2:0]       m_cyc, m_stb, m_wen;
    logic [2:0][3:0]  m_sel;
    logic [2:0][31:0] m_dat, m_adr;
    logic [2:0][2:0]  m_cti;
    logic [2:0]       o_m_ack, o_m_err, o_gnt;
    logic             o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt;
    logic [3:0]       o_wb_sel_nxt;
    logic [31:0]      o_wb_dat_nxt, o_wb_adr_nxt;
    logic [2:0]       o_wb_cti_nxt;
    logic             o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]       o_wb_sel;
    logic [31:0]      o_wb_dat, o_wb_adr;
    logic [2:0]       o_wb_cti;
    logic             i_wb_ack, i_wb_err;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    zap_wb_arbiter_n #(.NUM_MASTERS(3)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m_cyc_nxt(m_cyc), .i_m_stb_nxt(m_stb), .i_m_wen_nxt(m_wen),
        .i_m_sel_nxt(m_sel), .i_m_dat_nxt(m_dat), .i_m_adr_nxt(m_adr),
        .i_m_cti_nxt(m_cti),
        .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_gnt(o_gnt),
        .o_wb_cyc_nxt(o_wb_cyc_nxt), .o_wb_stb_nxt(o_wb_stb_nxt), .o_wb_wen_nxt(o_wb_wen_nxt),
        .o_wb_sel_nxt(o_wb_sel_nxt), .o_wb_dat_nxt(o_wb_dat_nxt), .o_wb_adr_nxt(o_wb_adr_nxt),
        .o_wb_cti_nxt(o_wb_cti_nxt),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_sel(o_wb_sel),
        .o_wb_dat(o_wb_dat), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
    );

    // The slave model must only respond to a strobed beat.
    always @(negedge i_clk) begin
        if ((i_wb_ack | i_wb_err) && !o_wb_stb && !i_reset) begin
            checks++;
            failures++;
            $display("FAIL slave_resp_no_stb got ack=%b err=%b stb=%b exp stb=1", i_wb_ack, i_wb_err, o_wb_stb);
        end
    end

    task automatic clr_all();
        m_cyc = '0; m_stb = '0; m_wen = '0; m_sel = '0; m_dat = '0; m_adr = '0;
        m_cti = {EOB, EOB, EOB};
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_wen[m] = (m == 1);
        m_sel[m] = 4'hF;
        m_adr[m] = adr;
        m_dat[m] = adr ^ 32'hA5A5_0000;
        m_cti[m] = cti;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        clr_all();
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        clr_all();
        m_cyc = 3'b111; m_stb = 3'b111;
        tick();
        tick();
        checks++; if (o_gnt !== 3'b001) begin failures++; $display("FAIL rst_gnt got=%b exp=001", o_gnt); end
        checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin failures++; $display("FAIL rst_cyc_stb got=%b%b exp=00", o_wb_cyc, o_wb_stb); end
        checks++; if (o_wb_cti !== EOB) begin failures++; $display("FAIL rst_cti got=%b exp=111", o_wb_cti); end
        checks++; if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_wen} !== 69'h0) begin failures++; $display("FAIL rst_bus got adr=%h dat=%h sel=%h wen=%b exp 0", o_wb_adr, o_wb_dat, o_wb_sel, o_wb_wen); end
        checks++; if (o_m_ack !== 3'b000 || o_m_err !== 3'b000) begin failures++; $display("FAIL rst_ackerr got=%b/%b exp=000/000", o_m_ack, o_m_err); end
        $display("test_reset done");
        clr_all();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_m(1, 1, 1, 32'h100, EOB);
        #1;
        checks++; if (o_wb_adr_nxt !== 32'h100 || o_wb_cyc_nxt !== 1'b1) begin failures++; $display("FAIL t1_adr_nxt got=%h cyc=%b exp=00000100 cyc=1", o_wb_adr_nxt, o_wb_cyc_nxt); end
        checks++; if (o_wb_dat_nxt !== 32'hA5A5_0100 || o_wb_wen_nxt !== 1'b1) begin failures++; $display("FAIL t1_dat_nxt got=%h wen=%b exp=a5a50100 wen=1", o_wb_dat_nxt, o_wb_wen_nxt); end
        tick();
        checks++; if (o_wb_adr !== 32'h100 || o_gnt !== 3'b010 || o_wb_stb !== 1'b1) begin failures++; $display("FAIL t1_reg got adr=%h gnt=%b stb=%b exp 00000100/010/1", o_wb_adr, o_gnt, o_wb_stb); end
        i_wb_ack = 1'b1;
        set_m(1, 0, 0, 32'h100, EOB);
        #1;
        checks++; if (o_m_ack !== 3'b010 || o_m_err !== 3'b000) begin failures++; $display("FAIL t1_ack got=%b err=%b exp=010/000", o_m_ack, o_m_err); end
        checks++; if (o_wb_cyc_nxt !== 1'b0) begin failures++; $display("FAIL t1_idle_nxt got=%b exp=0", o_wb_cyc_nxt); end
        tick();
        i_wb_ack = 1'b0;
        checks++; if (o_wb_cyc !== 1'b0 || o_gnt !== 3'b010) begin failures++; $display("FAIL t1_hold got cyc=%b gnt=%b exp 0/010", o_wb_cyc, o_gnt); end
        $display("test_single adr=%h gnt=%b", o_wb_adr, o_gnt);
    endtask

    task automatic test_priority();
        set_m(0, 1, 1, 32'h300, EOB);
        set_m(2, 1, 1, 32'h200, EOB);
        #1;
        checks++; if (o_wb_adr_nxt !== 32'h200) begin failures++; $display("FAIL t2_pick got=%h exp=00000200", o_wb_adr_nxt); end
        tick();
        checks++; if (o_gnt !== 3'b100 || o_wb_adr !== 32'h200) begin failures++; $display("FAIL t2_gnt2 got gnt=%b adr=%h exp 100/00000200", o_gnt, o_wb_adr); end
        i_wb_ack = 1'b1;
        set_m(2, 0, 0, 32'h200, EOB);
        #1;
        checks++; if (o_m_ack !== 3'b100 || o_wb_adr_nxt !== 32'h300) begin failures++; $display("FAIL t2_handover got ack=%b adr_nxt=%h exp 100/00000300", o_m_ack, o_wb_adr_nxt); end
        tick();
        i_wb_ack = 1'b0;
        checks++; if (o_gnt !== 3'b001 || o_wb_adr !== 32'h300) begin failures++; $display("FAIL t2_gnt0 got gnt=%b adr=%h exp 001/00000300", o_gnt, o_wb_adr); end
        i_wb_ack = 1'b1;
        set_m(0, 0, 0, 32'h300, EOB);
        tick();
        i_wb_ack = 1'b0;
        $display("test_priority gnt=%b", o_gnt);
    endtask

    task automatic test_burst_lock();
        set_m(0, 1, 1, 32'h0, BURST);
        tick();
        checks++; if (o_wb_adr !== 32'h0 || o_gnt !== 3'b001) begin failures++; $display("FAIL t3_b1 got adr=%h gnt=%b exp 00000000/001", o_wb_adr, o_gnt); end
        i_wb_ack = 1'b1;
        set_m(0, 1, 1, 32'h4, BURST);
        tick();
        checks++; if (o_wb_adr !== 32'h4) begin failures++; $display("FAIL t3_b2 got adr=%h exp 00000004", o_wb_adr); end
        set_m(0, 1, 1, 32'h8, BURST);
        set_m(2, 1, 1, 32'h200, EOB);
        #1;
        checks++; if (o_wb_adr_nxt !== 32'h8) begin failures++; $display("FAIL t3_lock_nxt got=%h exp 00000008", o_wb_adr_nxt); end
        tick();
        checks++; if (o_wb_adr !== 32'h8 || o_gnt !== 3'b001) begin failures++; $display("FAIL t3_b3 got adr=%h gnt=%b exp 00000008/001", o_wb_adr, o_gnt); end
        set_m(0, 1, 1, 32'hC, EOB);
        tick();
        i_wb_ack = 1'b0;
        #1;
        checks++; if (o_wb_adr !== 32'hC || o_wb_cti !== EOB || o_wb_adr_nxt !== 32'hC) begin failures++; $display("FAIL t3_b4 got adr=%h cti=%b nxt=%h exp 0000000c/111/0000000c", o_wb_adr, o_wb_cti, o_wb_adr_nxt); end
        i_wb_ack = 1'b1;
        set_m(0, 0, 0, 32'hC, EOB);
        #1;
        checks++; if (o_wb_adr_nxt !== 32'h200) begin failures++; $display("FAIL t3_release got=%h exp 00000200", o_wb_adr_nxt); end
        tick();
        i_wb_ack = 1'b0;
        checks++; if (o_gnt !== 3'b100 || o_wb_adr !== 32'h200) begin failures++; $display("FAIL t3_gnt2 got gnt=%b adr=%h exp 100/00000200", o_gnt, o_wb_adr); end
        i_wb_ack = 1'b1;
        set_m(2, 0, 0, 32'h200, EOB);
        tick();
        i_wb_ack = 1'b0;
        $display("test_burst_lock gnt=%b", o_gnt);
    endtask

    task automatic test_error();
        set_m(1, 1, 1, 32'h40, BURST);
        tick();
        checks++; if (o_gnt !== 3'b010) begin failures++; $display("FAIL t4_gnt1 got=%b exp 010", o_gnt); end
        i_wb_ack = 1'b1;
        set_m(1, 1, 1, 32'h44, BURST);
        tick();
        i_wb_ack = 1'b0;
        i_wb_err = 1'b1;
        set_m(1, 1, 0, 32'h44, BURST);
        set_m(0, 1, 1, 32'h500, EOB);
        #1;
        checks++; if (o_m_err !== 3'b010 || o_m_ack !== 3'b000) begin failures++; $display("FAIL t4_route got err=%b ack=%b exp 010/000", o_m_err, o_m_ack); end
        checks++; if (o_wb_adr_nxt !== 32'h44 || o_wb_cyc_nxt !== 1'b1) begin failures++; $display("FAIL t4_err_hold got adr=%h cyc=%b exp 00000044/1", o_wb_adr_nxt, o_wb_cyc_nxt); end
        tick();
        i_wb_err = 1'b0;
        #1;
        checks++; if (o_gnt !== 3'b010 || o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0 || o_wb_adr_nxt !== 32'h44) begin failures++; $display("FAIL t4_locked got gnt=%b cyc=%b stb=%b nxt=%h exp 010/1/0/00000044", o_gnt, o_wb_cyc, o_wb_stb, o_wb_adr_nxt); end
        set_m(1, 0, 0, 32'h44, BURST);
        #1;
        checks++; if (o_wb_adr_nxt !== 32'h500) begin failures++; $display("FAIL t4_rearb got=%h exp 00000500", o_wb_adr_nxt); end
        tick();
        checks++; if (o_gnt !== 3'b001 || o_wb_adr !== 32'h500) begin failures++; $display("FAIL t4_gnt0 got gnt=%b adr=%h exp 001/00000500", o_gnt, o_wb_adr); end
        i_wb_ack = 1'b1;
        set_m(0, 0, 0, 32'h500, EOB);
        tick();
        i_wb_ack = 1'b0;
        $display("test_error gnt=%b", o_gnt);
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g [6];
        logic [31:0] exp_a;
`ifdef ZAP_WB_ARB_RR_EN
        exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
        do_reset();
        set_m(0, 1, 1, 32'h1000, EOB);
        set_m(1, 1, 1, 32'h2000, EOB);
        set_m(2, 1, 1, 32'h3000, EOB);
        tick();
        i_wb_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_a = (exp_g[k] == 3'b001) ? 32'h1000 : (exp_g[k] == 3'b010) ? 32'h2000 : 32'h3000;
            checks++; if (o_gnt !== exp_g[k] || o_wb_adr !== exp_a) begin failures++; $display("FAIL t5_order[%0d] got gnt=%b adr=%h exp %b/%h", k, o_gnt, o_wb_adr, exp_g[k], exp_a); end
            $display("test_round_robin beat %0d gnt=%b adr=%h", k, o_gnt, o_wb_adr);
        end
        clr_all();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_m(1, 1, 1, 32'h80, BURST);
        tick();
        i_wb_ack = 1'b1;
        set_m(1, 1, 1, 32'h84, BURST);
        tick();
        i_wb_ack = 1'b0;
        i_reset  = 1'b1;
        #1;
        checks++; if (o_gnt !== 3'b010 || o_wb_stb !== 1'b1 || o_wb_adr !== 32'h84) begin failures++; $display("FAIL t6_pre got gnt=%b stb=%b adr=%h exp 010/1/00000084", o_gnt, o_wb_stb, o_wb_adr); end
        tick();
        clr_all();
        #1;
        checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_gnt !== 3'b001 || o_wb_cti !== EOB) begin failures++; $display("FAIL t6_post got cyc=%b stb=%b gnt=%b cti=%b exp 0/0/001/111", o_wb_cyc, o_wb_stb, o_gnt, o_wb_cti); end
        checks++; if (o_wb_adr !== 32'h0 || o_m_ack !== 3'b000) begin failures++; $display("FAIL t6_bus got adr=%h ack=%b exp 00000000/000", o_wb_adr, o_m_ack); end
        i_reset = 1'b0;
        tick();
        $display("test_reset_mid_burst gnt=%b cyc=%b", o_gnt, o_wb_cyc);
    endtask

    initial begin
        clr_all();
        i_reset = 1'b1;
        test_reset();
        test_single();
        test_priority();
        test_burst_lock();
        test_error();
        test_round_robin();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_zap_wb_arbiter_n
